wb_arbiter_rr_4: RTL and testbench
==================================

WB_ARBITER_RR_4 -- requirements
Module: wb_arbiter_rr_4

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, data bus width in bits (8/16/32/64).
REQ-002 SHALL have parameter ADDR_WIDTH, default 32, address bus width in bits.
REQ-003 SHALL have parameter SELECT_WIDTH, default DATA_WIDTH/8, byte select width.
REQ-004 SHALL have parameter MAX_XFER, default 8, terminated transfers per grant before preemption (1..255).
REQ-005 SHALL have parameter TIMEOUT, default 255, stall cycles before forced error (2..65535).
REQ-006 SHALL have ports: clk  input  1  single clock; all logic on rising edge.
REQ-007 SHALL have ports: rst  input  1  reset, synchronous, active-high.
REQ-008 SHALL have master-side flattened buses; master n occupies slice [n*W +: W]: wbm_adr_i in 4*ADDR_WIDTH, wbm_dat_i in 4*DATA_WIDTH, wbm_dat_o out 4*DATA_WIDTH, wbm_we_i in 4, wbm_sel_i in 4*SELECT_WIDTH, wbm_stb_i in 4, wbm_cyc_i in 4, wbm_ack_o out 4, wbm_err_o out 4, wbm_rty_o out 4.
REQ-009 SHALL have slave-side ports: wbs_adr_o out ADDR_WIDTH, wbs_dat_i in DATA_WIDTH, wbs_dat_o out DATA_WIDTH, wbs_we_o out 1, wbs_sel_o out SELECT_WIDTH, wbs_stb_o out 1, wbs_ack_i in 1, wbs_err_i in 1, wbs_rty_i in 1, wbs_cyc_o out 1.
REQ-010 SHALL have grant_o  output  4  registered one-hot current grant (0 = none).

Function
REQ-011 SHALL implement states IDLE, GRANT, HOLDOFF; request n = wbm_cyc_i[n].
REQ-012 SHALL arbitrate in IDLE and HOLDOFF: round-robin starting at (last_grant+1) mod 4; winner registered into grant_o, state GRANT next cycle (request at cycle t -> wbs_cyc_o at t+1).
REQ-013 SHALL drive wbs_adr/dat/we/sel from the granted master; wbs_cyc_o = granted master cyc; wbs_stb_o = granted master stb unless masked (REQ-017); all slave outputs 0 when grant_o = 0.
REQ-014 SHALL broadcast wbs_dat_i to every wbm_dat_o slice; ack/err/rty routed only to the granted master, combinationally, zero latency.
REQ-015 SHALL count terminations (ack|err|rty while wbs_stb_o) in an 8-bit xfer_cnt, cleared on every new grant.
REQ-016 SHALL release on granted master cyc low in GRANT: next cycle HOLDOFF (grant_o = 0 exactly one cycle), new grant at t+2.
REQ-017 SHALL preempt when xfer_cnt reaches MAX_XFER and another master requests: the terminating cycle is the last; next cycle HOLDOFF; preempted master sees no stb forwarded until re-granted.
REQ-018 SHALL, on quota reached with no other requester, clear xfer_cnt and retain grant.
REQ-019 SHALL update last_grant on every grant; ties impossible (round-robin order is total).
REQ-020 SHALL give master cyc drop priority over quota and timeout in the same cycle.

Reset
REQ-021 SHALL on rst high at a clock edge: state IDLE, grant_o 0, last_grant 3 (master 0 first), xfer_cnt 0, timeout counter 0; all slave outputs and wbm ack/err/rty 0 from the following cycle.
REQ-022 SHALL abort an in-flight transfer on mid-operation reset without issuing any ack/err to the master.

Configuration
REQ-023 SHALL, with macro WB_ARBITER_RR_TIMEOUT_EN defined, count cycles wbs_stb_o high with no ack/err/rty; at count TIMEOUT assert wbm_err_o[granted] one cycle, force wbs_stb_o 0 that cycle, then HOLDOFF; counter clears on any termination or grant change.
REQ-024 SHALL, without WB_ARBITER_RR_TIMEOUT_EN, omit the counter entirely; a stalled slave holds the grant indefinitely.

Verification
REQ-025 Reset release, masters 0 and 2 raise cyc same cycle t -> grant_o 4'b0001 at t+1; master 0 drops cyc at t+5 -> grant_o 0 at t+6, 4'b0100 at t+7.
REQ-026 All four masters request continuously, MAX_XFER=2, slave acks every stb -> grant sequence 0,1,2,3,0 with one HOLDOFF cycle between each, exactly 2 acks per grant.
REQ-027 Single master 1, MAX_XFER=2, 6 back-to-back acks -> grant_o stays 4'b0010, no HOLDOFF.
REQ-028 WB_ARBITER_RR_TIMEOUT_EN, TIMEOUT=10, slave never acks -> wbm_err_o[0] pulse at 10th stall cycle, wbs_stb_o 0 that cycle, HOLDOFF next.
REQ-029 Reset asserted mid-transfer while wbs_ack_i high -> no wbm_ack_o after edge; grant_o 0; after release, master 0 wins first.

Source files
------------

// File: rtl/wb_arbiter_rr_4.sv
// Round-robin Wishbone arbiter: four masters share one slave, with a per-grant transfer quota.
// Define WB_ARBITER_RR_TIMEOUT_EN to add the stalled-slave timeout (forced error + release).
module wb_arbiter_rr_4 #(
   parameter int DATA_WIDTH   = 32,
   parameter int ADDR_WIDTH   = 32,
   parameter int SELECT_WIDTH = DATA_WIDTH/8,
   parameter int MAX_XFER     = 8,
   parameter int TIMEOUT      = 255
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [4*ADDR_WIDTH-1:0]   wbm_adr_i,
   input  logic [4*DATA_WIDTH-1:0]   wbm_dat_i,
   output logic [4*DATA_WIDTH-1:0]   wbm_dat_o,
   input  logic [3:0]                wbm_we_i,
   input  logic [4*SELECT_WIDTH-1:0] wbm_sel_i,
   input  logic [3:0]                wbm_stb_i,
   input  logic [3:0]                wbm_cyc_i,
   output logic [3:0]                wbm_ack_o,
   output logic [3:0]                wbm_err_o,
   output logic [3:0]                wbm_rty_o,
   output logic [ADDR_WIDTH-1:0]     wbs_adr_o,
   input  logic [DATA_WIDTH-1:0]     wbs_dat_i,
   output logic [DATA_WIDTH-1:0]     wbs_dat_o,
   output logic                      wbs_we_o,
   output logic [SELECT_WIDTH-1:0]   wbs_sel_o,
   output logic                      wbs_stb_o,
   input  logic                      wbs_ack_i,
   input  logic                      wbs_err_i,
   input  logic                      wbs_rty_i,
   output logic                      wbs_cyc_o,
   output logic [3:0]                grant_o
);

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_GRANT   = 2'd1;
   localparam logic [1:0] ST_HOLDOFF = 2'd2;
   localparam logic [7:0] QUOTA_LAST = 8'(MAX_XFER - 1);

   logic [1:0] state_q, state_d;
   logic [3:0] grant_q, grant_d;
   logic [1:0] last_q, last_d;
   logic [7:0] xfer_cnt_q, xfer_cnt_d;

   logic [1:0] winner_s;
   logic       winner_vld_s;
   logic [1:0] gidx_s;
   logic       granted_s;
   logic       g_cyc_s;
   logic       g_stb_s;
   logic       term_s;
   logic       quota_s;
   logic       other_req_s;
   logic       timeout_hit_s;

   // Round-robin pick: scan downward so the closest requester after last_q wins.
   always_comb begin
      winner_vld_s = 1'b0;
      winner_s     = 2'd0;
      for (int k = 4; k >= 1; k--) begin
         if (wbm_cyc_i[2'(last_q + 2'(k))]) begin
            winner_vld_s = 1'b1;
            winner_s     = 2'(last_q + 2'(k));
         end
      end
   end

   // One-hot grant to index.
   always_comb begin
      case (grant_q)
         4'b0001: gidx_s = 2'd0;
         4'b0010: gidx_s = 2'd1;
         4'b0100: gidx_s = 2'd2;
         4'b1000: gidx_s = 2'd3;
         default: gidx_s = 2'd0;
      endcase
   end

   assign granted_s   = |grant_q;
   assign g_cyc_s     = granted_s & wbm_cyc_i[gidx_s];
   assign g_stb_s     = granted_s & wbm_stb_i[gidx_s];
   assign other_req_s = |(wbm_cyc_i & ~grant_q);

   assign wbs_adr_o = granted_s ? wbm_adr_i[gidx_s*ADDR_WIDTH +: ADDR_WIDTH] : {ADDR_WIDTH{1'b0}};
   assign wbs_dat_o = granted_s ? wbm_dat_i[gidx_s*DATA_WIDTH +: DATA_WIDTH] : {DATA_WIDTH{1'b0}};
   assign wbs_sel_o = granted_s ? wbm_sel_i[gidx_s*SELECT_WIDTH +: SELECT_WIDTH] : {SELECT_WIDTH{1'b0}};
   assign wbs_we_o  = granted_s & wbm_we_i[gidx_s];
   assign wbs_cyc_o = g_cyc_s;
   assign wbs_stb_o = g_stb_s & ~timeout_hit_s;

   assign term_s  = wbs_stb_o & (wbs_ack_i | wbs_err_i | wbs_rty_i);
   assign quota_s = term_s & (xfer_cnt_q == QUOTA_LAST);

   assign wbm_dat_o = {4{wbs_dat_i}};
   assign wbm_ack_o = grant_q & {4{wbs_ack_i}};
   assign wbm_err_o = grant_q & {4{wbs_err_i | timeout_hit_s}};
   assign wbm_rty_o = grant_q & {4{wbs_rty_i}};
   assign grant_o   = grant_q;

   // Next-state: a cyc drop outranks timeout, which outranks quota preemption.
   always_comb begin
      state_d    = state_q;
      grant_d    = grant_q;
      last_d     = last_q;
      xfer_cnt_d = xfer_cnt_q;
      case (state_q)
         ST_IDLE, ST_HOLDOFF: begin
            if (winner_vld_s) begin
               state_d    = ST_GRANT;
               grant_d    = 4'b0001 << winner_s;
               last_d     = winner_s;
               xfer_cnt_d = 8'd0;
            end else begin
               state_d = ST_IDLE;
               grant_d = 4'b0000;
            end
         end
         ST_GRANT: begin
            if (!g_cyc_s || timeout_hit_s || (quota_s && other_req_s)) begin
               state_d = ST_HOLDOFF;
               grant_d = 4'b0000;
            end else if (quota_s) begin
               xfer_cnt_d = 8'd0;
            end else if (term_s) begin
               xfer_cnt_d = xfer_cnt_q + 8'd1;
            end else begin
               xfer_cnt_d = xfer_cnt_q;
            end
         end
         default: begin
            state_d = ST_IDLE;
            grant_d = 4'b0000;
         end
      endcase
   end

   // Arbiter state registers; last_q resets to 3 so master 0 is first.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         grant_q    <= 4'b0000;
         last_q     <= 2'd3;
         xfer_cnt_q <= 8'd0;
      end else begin
         state_q    <= state_d;
         grant_q    <= grant_d;
         last_q     <= last_d;
         xfer_cnt_q <= xfer_cnt_d;
      end
   end

`ifdef WB_ARBITER_RR_TIMEOUT_EN
   localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);
   logic [15:0] to_cnt_q, to_cnt_d;

   assign timeout_hit_s = (state_q == ST_GRANT) & g_cyc_s & g_stb_s & (to_cnt_q == TO_LAST);

   // Stall counter restarts on any termination and whenever the grant is not held.
   always_comb begin
      if ((state_q != ST_GRANT) || (state_d != ST_GRANT) || term_s) begin
         to_cnt_d = 16'd0;
      end else if (g_stb_s) begin
         to_cnt_d = to_cnt_q + 16'd1;
      end else begin
         to_cnt_d = to_cnt_q;
      end
   end

   // Stall counter register.
   always_ff @(posedge clk) begin
      if (rst) begin
         to_cnt_q <= 16'd0;
      end else begin
         to_cnt_q <= to_cnt_d;
      end
   end
`else
   assign timeout_hit_s = 1'b0;
`endif

endmodule

// File: tb/tb_wb_arbiter_rr_4.sv
// Bench for wb_arbiter_rr_4: directed scenarios plus random traffic against an ownership model.
module tb_wb_arbiter_rr_4;
   localparam int DW = 16;
   localparam int AW = 16;
   localparam int SW = 2;
   localparam int MAXX = 2;
   localparam int TOUT = 10;
`ifdef WB_ARBITER_RR_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst;
   logic [4*AW-1:0] wbm_adr_i;
   logic [4*DW-1:0] wbm_dat_i, wbm_dat_o;
   logic [3:0] wbm_we_i, wbm_stb_i, wbm_cyc_i, wbm_ack_o, wbm_err_o, wbm_rty_o;
   logic [4*SW-1:0] wbm_sel_i;
   logic [AW-1:0] wbs_adr_o;
   logic [DW-1:0] wbs_dat_i, wbs_dat_o;
   logic wbs_we_o, wbs_stb_o, wbs_ack_i, wbs_err_i, wbs_rty_i, wbs_cyc_o;
   logic [SW-1:0] wbs_sel_o;
   logic [3:0] grant_o;

   int n_assert = 0;
   int n_fail = 0;
   int m_owner, m_last, m_cnt, m_to;
   int ack_cnt [4];
   logic [3:0] obs_ack, obs_err;
   logic obs_stb;
   logic [3:0] exp25 [8];
   logic [3:0] exp26 [13];
   logic [3:0] exp27 [7];
   logic [3:0] exp28 [13];
   logic [3:0] e28_err;
   logic e28_stb;

   wb_arbiter_rr_4 #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .SELECT_WIDTH(SW),
                     .MAX_XFER(MAXX), .TIMEOUT(TOUT)) dut (
      .clk(clk), .rst(rst),
      .wbm_adr_i(wbm_adr_i), .wbm_dat_i(wbm_dat_i), .wbm_dat_o(wbm_dat_o),
      .wbm_we_i(wbm_we_i), .wbm_sel_i(wbm_sel_i), .wbm_stb_i(wbm_stb_i),
      .wbm_cyc_i(wbm_cyc_i), .wbm_ack_o(wbm_ack_o), .wbm_err_o(wbm_err_o),
      .wbm_rty_o(wbm_rty_o), .wbs_adr_o(wbs_adr_o), .wbs_dat_i(wbs_dat_i),
      .wbs_dat_o(wbs_dat_o), .wbs_we_o(wbs_we_o), .wbs_sel_o(wbs_sel_o),
      .wbs_stb_o(wbs_stb_o), .wbs_ack_i(wbs_ack_i), .wbs_err_i(wbs_err_i),
      .wbs_rty_i(wbs_rty_i), .wbs_cyc_o(wbs_cyc_o), .grant_o(grant_o));

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic [3:0] c, input logic [3:0] s, input logic a);
      wbm_cyc_i = c;
      wbm_stb_i = s;
      wbs_ack_i = a;
      wbs_err_i = 1'b0;
      wbs_rty_i = 1'b0;
      wbm_adr_i = {$urandom(), $urandom()};
      wbm_dat_i = {$urandom(), $urandom()};
      wbm_sel_i = 8'($urandom());
      wbm_we_i  = 4'($urandom());
      wbs_dat_i = 16'($urandom());
   endtask

   // One clock: compare all outputs with the ownership model, then advance the model.
   task automatic step();
      logic [3:0] e_grant;
      logic e_cyc, e_stb, e_we;
      logic [AW-1:0] e_adr;
      logic [DW-1:0] e_dat;
      logic [SW-1:0] e_sel;
      bit to_hit, term, found;
      int cand;
      #2;
      to_hit = 1'b0;
      e_grant = 4'b0000; e_cyc = 1'b0; e_stb = 1'b0; e_we = 1'b0;
      e_adr = '0; e_dat = '0; e_sel = '0;
      if (m_owner >= 0) begin
         e_grant = 4'b0001 << m_owner;
         to_hit = TO_EN && wbm_cyc_i[m_owner] && wbm_stb_i[m_owner] && (m_to == TOUT - 1);
         e_cyc = wbm_cyc_i[m_owner];
         e_stb = wbm_stb_i[m_owner] && !to_hit;
         e_we  = wbm_we_i[m_owner];
         e_adr = wbm_adr_i[m_owner*AW +: AW];
         e_dat = wbm_dat_i[m_owner*DW +: DW];
         e_sel = wbm_sel_i[m_owner*SW +: SW];
      end
      chk("grant", grant_o, e_grant);
      chk("wbs_cyc", wbs_cyc_o, e_cyc);
      chk("wbs_stb", wbs_stb_o, e_stb);
      chk("wbs_we", wbs_we_o, e_we);
      chk("wbs_adr", wbs_adr_o, e_adr);
      chk("wbs_dat", wbs_dat_o, e_dat);
      chk("wbs_sel", wbs_sel_o, e_sel);
      chk("wbm_dat", wbm_dat_o, {4{wbs_dat_i}});
      chk("wbm_ack", wbm_ack_o, e_grant & {4{wbs_ack_i}});
      chk("wbm_err", wbm_err_o, e_grant & {4{wbs_err_i | to_hit}});
      chk("wbm_rty", wbm_rty_o, e_grant & {4{wbs_rty_i}});
      obs_ack = wbm_ack_o;
      obs_err = wbm_err_o;
      obs_stb = wbs_stb_o;
      for (int i = 0; i < 4; i++) if (wbm_ack_o[i]) ack_cnt[i]++;
      term = e_stb && (wbs_ack_i || wbs_err_i || wbs_rty_i);
      if (rst) begin
         m_owner = -1; m_last = 3; m_cnt = 0; m_to = 0;
      end else if (m_owner < 0) begin
         found = 1'b0;
         for (int k = 1; k <= 4; k++) begin
            cand = (m_last + k) % 4;
            if (!found && wbm_cyc_i[cand]) begin
               found = 1'b1;
               m_owner = cand;
            end
         end
         if (found) begin
            m_last = m_owner; m_cnt = 0; m_to = 0;
         end
      end else if (!wbm_cyc_i[m_owner] || to_hit) begin
         m_owner = -1;
      end else if (term) begin
         m_cnt++;
         m_to = 0;
         if (m_cnt == MAXX) begin
            m_cnt = 0;
            if ((wbm_cyc_i & ~(4'b0001 << m_owner)) != 4'b0000) m_owner = -1;
         end
      end else if (e_stb) begin
         m_to++;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      drive(4'b0000, 4'b0000, 1'b0);
      step();
      step();
      rst = 1'b0;
      for (int i = 0; i < 4; i++) ack_cnt[i] = 0;
   endtask

   initial begin
      logic [3:0] c, s;
      int r;
      bit busy;
      exp25 = '{4'h0, 4'h1, 4'h1, 4'h1, 4'h1, 4'h1, 4'h0, 4'h4};
      exp26 = '{4'h0, 4'h1, 4'h1, 4'h0, 4'h2, 4'h2, 4'h0, 4'h4, 4'h4, 4'h0, 4'h8, 4'h8, 4'h0};
      exp27 = '{4'h0, 4'h2, 4'h2, 4'h2, 4'h2, 4'h2, 4'h2};
`ifdef WB_ARBITER_RR_TIMEOUT_EN
      exp28 = '{4'h0, 4'h1, 4'h1, 4'h1, 4'h1, 4'h1, 4'h1, 4'h1, 4'h1, 4'h1, 4'h1, 4'h0, 4'h1};
      e28_err = 4'b0001;
      e28_stb = 1'b0;
`else
      exp28 = '{4'h0, 4'h1, 4'h1, 4'h1, 4'h1, 4'h1, 4'h1, 4'h1, 4'h1, 4'h1, 4'h1, 4'h1, 4'h1};
      e28_err = 4'b0000;
      e28_stb = 1'b1;
`endif
      rst = 1'b1;
      drive(4'b0000, 4'b0000, 1'b0);
      repeat (2) @(posedge clk);
      #1;
      m_owner = -1; m_last = 3; m_cnt = 0; m_to = 0;
      rst = 1'b0;
      chk("reset_grant", grant_o, 4'b0000);

      // Masters 0 and 2 together; 0 wins, drops at t+5, 2 follows after one idle cycle.
      for (int i = 0; i < 8; i++) begin
         chk("req025_grant", grant_o, exp25[i]);
         drive((i < 5) ? 4'b0101 : 4'b0100, (i < 5) ? 4'b0101 : 4'b0100, 1'b0);
         step();
      end

      // All four request with an always-acking slave: quota 2, rotating grants.
      do_reset();
      for (int i = 0; i < 13; i++) begin
         chk("req026_grant", grant_o, exp26[i]);
         drive(4'b1111, 4'b1111, 1'b1);
         step();
      end
      for (int i = 0; i < 4; i++) chk("req026_acks", 64'(ack_cnt[i]), 64'd2);
      chk("req026_wrap", grant_o, 4'b0001);

      // Lone master 1 keeps the grant across quota boundaries.
      do_reset();
      for (int i = 0; i < 7; i++) begin
         chk("req027_grant", grant_o, exp27[i]);
         drive(4'b0010, 4'b0010, 1'b1);
         step();
      end
      chk("req027_acks", 64'(ack_cnt[1]), 64'd6);

      // Slave never answers.
      do_reset();
      for (int i = 0; i < 13; i++) begin
         chk("req028_grant", grant_o, exp28[i]);
         drive(4'b0001, 4'b0001, 1'b0);
         step();
         if (i == 10) begin
            chk("req028_err", obs_err, e28_err);
            chk("req028_stb", obs_stb, e28_stb);
         end
      end

      // Reset in the middle of an acknowledged transfer.
      do_reset();
      for (int i = 0; i < 3; i++) begin
         drive(4'b0001, 4'b0001, 1'b1);
         step();
      end
      rst = 1'b1;
      drive(4'b0111, 4'b0111, 1'b1);
      step();
      chk("req029_grant_rst", grant_o, 4'b0000);
      rst = 1'b0;
      step();
      chk("req029_no_ack", obs_ack, 4'b0000);
      chk("req029_first", grant_o, 4'b0001);

      // Random traffic, alternating responsive and sluggish slave phases.
      do_reset();
      c = 4'b0000;
      busy = 1'b0;
      for (int n = 0; n < 3000; n++) begin
         if ((n % 256) == 0) busy = ~busy;
         for (int m = 0; m < 4; m++) if ($urandom_range(0, 7) == 0) c[m] = ~c[m];
         s = c & 4'($urandom());
         s = s | (c & 4'($urandom()));
         drive(c, s, 1'b0);
         r = busy ? $urandom_range(0, 31) : $urandom_range(0, 7);
         wbs_ack_i = (r <= 2);
         wbs_err_i = (r == 3);
         wbs_rty_i = (r == 4);
         rst = ($urandom_range(0, 299) == 0);
         step();
      end
      rst = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
